// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - SPI mode-0 slave port with CPU-side control/status/data registers
// Optional 4-entry RX FIFO selected by defining SPI_SLAVE_RX_FIFO_EN.
module spi_slave_port (
    input  logic       clk,
    input  logic       _reset,
    input  logic       _cs,
    input  logic       _rd,
    input  logic       _wr,
    input  logic [1:0] addr,
    inout  wire  [7:0] data,
    output logic       irq,
    input  logic       _ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso
);
    logic [2:0] ss_pipe_q, ss_pipe_d, sclk_pipe_q, sclk_pipe_d;
    logic [1:0] mosi_pipe_q, mosi_pipe_d;
    logic       rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_empty_q, tx_empty_d;
    logic       ovr_q, ovr_d, udr_q, udr_d;
    logic [7:0] shift_q, shift_d;
    logic       rx_bit_q, rx_bit_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_pend_q, load_pend_d, push_pend_q, push_pend_d;
    logic [7:0] rdata_q, rdata_d;
    logic       irq_q, irq_d;

    logic       rd_act, wr_act, rd_start, wr_start, pop, push_now;
    logic       ss_fall, ss_rise, sclk_rise, sclk_fall, active, load_now;
    logic [7:0] push_byte, rx_head;
    logic       rx_full, rx_drop;

    assign rd_act    = ~_cs & ~_rd;
    assign wr_act    = ~_cs & ~_wr;
    assign rd_start  = rd_act & ~rd_prev_q;
    assign wr_start  = wr_act & ~wr_prev_q;
    assign pop       = rd_start & (addr == 2'd2);
    assign ss_fall   = ss_pipe_q[2] & ~ss_pipe_q[1];
    assign ss_rise   = ~ss_pipe_q[2] & ss_pipe_q[1];
    assign active    = ~ss_pipe_q[2] & ~ss_pipe_q[1];
    assign sclk_rise = ~sclk_pipe_q[2] & sclk_pipe_q[1];
    assign sclk_fall = sclk_pipe_q[2] & ~sclk_pipe_q[1];
    // A completed byte is pushed the cycle after its last bit was sampled.
    assign push_now  = push_pend_q;
    assign push_byte = {shift_q[6:0], rx_bit_q};

    assign data = rd_act ? rdata_q : 8'hzz;
    assign miso = (~ss_pipe_q[2] & ctrl_q[2]) ? shift_q[7] : 1'bz;
    assign irq  = irq_q;

    always_comb begin
        ss_pipe_d   = {ss_pipe_q[1:0], _ss};
        sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
        mosi_pipe_d = {mosi_pipe_q[0], mosi};
        rd_prev_d   = rd_act;
        wr_prev_d   = wr_act;
        ctrl_d      = ctrl_q;
        tx_hold_d   = tx_hold_q;
        tx_empty_d  = tx_empty_q;
        ovr_d       = ovr_q;
        udr_d       = udr_q;
        shift_d     = shift_q;
        rx_bit_d    = rx_bit_q;
        cnt_d       = cnt_q;
        load_pend_d = load_pend_q;
        push_pend_d = 1'b0;
        rdata_d     = rdata_q;
        load_now    = 1'b0;

        // Status clears come first so a same-cycle new event still sets the flag.
        if (rd_start) begin
            case (addr)
                2'd0: rdata_d = {5'd0, ctrl_q};
                2'd1: begin
                    rdata_d = {3'd0, ~ss_pipe_q[2], udr_q, ovr_q, tx_empty_q, rx_full};
                    ovr_d   = 1'b0;
                    udr_d   = 1'b0;
                end
                2'd2:    rdata_d = rx_full ? rx_head : 8'h00;
                default: rdata_d = 8'h00;
            endcase
        end

        if (ss_rise || ss_fall) begin
            cnt_d       = 3'd0;
            load_pend_d = 1'b0;
        end
        if (ss_fall) load_now = 1'b1;

        if (active && sclk_rise) begin
            rx_bit_d = mosi_pipe_q[1];
            if (cnt_q == 3'd7) begin
                cnt_d       = 3'd0;
                push_pend_d = 1'b1;
                load_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
        if (active && sclk_fall) begin
            if (load_pend_q) begin
                load_now    = 1'b1;
                load_pend_d = 1'b0;
            end else begin
                shift_d = {shift_q[6:0], rx_bit_q};
            end
        end

        if (load_now) begin
            if (tx_empty_q) begin
                shift_d = 8'hFF;
                udr_d   = 1'b1;
            end else begin
                shift_d = tx_hold_q;
            end
            tx_empty_d = 1'b1;
        end

        // A CPU write in the same cycle as a load wins: holding gets the new byte.
        if (wr_start) begin
            case (addr)
                2'd0: ctrl_d = data[2:0];
                2'd2: begin
                    tx_hold_d  = data;
                    tx_empty_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (rx_drop) ovr_d = 1'b1;
        irq_d = (ctrl_q[0] & rx_full) | (ctrl_q[1] & tx_empty_q);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ss_pipe_q   <= 3'b111;
            sclk_pipe_q <= 3'b000;
            mosi_pipe_q <= 2'b00;
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            ctrl_q      <= 3'd0;
            tx_hold_q   <= 8'h00;
            tx_empty_q  <= 1'b1;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
            shift_q     <= 8'hFF;
            rx_bit_q    <= 1'b0;
            cnt_q       <= 3'd0;
            load_pend_q <= 1'b0;
            push_pend_q <= 1'b0;
            rdata_q     <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            ss_pipe_q   <= ss_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
            ctrl_q      <= ctrl_d;
            tx_hold_q   <= tx_hold_d;
            tx_empty_q  <= tx_empty_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
            shift_q     <= shift_d;
            rx_bit_q    <= rx_bit_d;
            cnt_q       <= cnt_d;
            load_pend_q <= load_pend_d;
            push_pend_q <= push_pend_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [7:0] rx_mem_q [4];
    logic [7:0] rx_mem_d [4];
    logic [1:0] rx_rptr_q, rx_rptr_d, rx_wptr_q, rx_wptr_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic       pop_ok, push_ok;

    assign rx_full = (rx_cnt_q != 3'd0);
    assign rx_head = rx_mem_q[rx_rptr_q];

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_rptr_d = rx_rptr_q;
        rx_wptr_d = rx_wptr_q;
        pop_ok    = pop & rx_full;
        push_ok   = push_now & ((rx_cnt_q != 3'd4) | pop_ok);
        rx_drop   = push_now & ~push_ok;
        if (push_ok) begin
            rx_mem_d[rx_wptr_q] = push_byte;
            rx_wptr_d           = rx_wptr_q + 2'd1;
        end
        if (pop_ok) rx_rptr_d = rx_rptr_q + 2'd1;
        rx_cnt_d = rx_cnt_q + {2'd0, push_ok} - {2'd0, pop_ok};
    end

    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rx_rptr_q <= 2'd0;
            rx_wptr_q <= 2'd0;
            rx_cnt_q  <= 3'd0;
        end else begin
            rx_rptr_q <= rx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_cnt_q  <= rx_cnt_d;
        end
    end
`else
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_full_q, rx_full_d;
    logic       pop_ok, push_ok;

    assign rx_full = rx_full_q;
    assign rx_head = rx_data_q;

    always_comb begin
        rx_data_d = rx_data_q;
        pop_ok    = pop & rx_full_q;
        push_ok   = push_now & (~rx_full_q | pop_ok);
        rx_drop   = push_now & ~push_ok;
        if (push_ok) rx_data_d = push_byte;
        rx_full_d = push_ok | (rx_full_q & ~pop_ok);
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rx_data_q <= 8'h00;
            rx_full_q <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
        end
    end
`endif

endmodule
